// File: rtl/xm23_run_controller.sv
// Run/step sequencer for the XM23 pipeline: boot-time PC force, clock-enable tick
// generation at a switch-selected rate or per step press, and finish-instruction halt.
module xm23_run_controller #(
  parameter int unsigned DIV_FAST    = 6,
  parameter int unsigned DIV_100HZ   = 500_000,
  parameter int unsigned DIV_10HZ    = 5_000_000,
  parameter int unsigned DIV_1HZ     = 50_000_000,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter logic [15:0] FINISH_INST = 16'h3FFF
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic [1:0]  speed,
  input  logic        run_mode,
  input  logic        step_btn,
  input  logic [15:0] inst,
  output logic        cpu_tick,
  output logic        pc_force,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic        led,
  output logic [1:0]  state
);

  localparam int unsigned DIV_MAX_A = (DIV_FAST > DIV_100HZ) ? DIV_FAST : DIV_100HZ;
  localparam int unsigned DIV_MAX_B = (DIV_10HZ > DIV_1HZ) ? DIV_10HZ : DIV_1HZ;
  localparam int unsigned DIV_MAX   = (DIV_MAX_A > DIV_MAX_B) ? DIV_MAX_A : DIV_MAX_B;
  localparam int          CW        = $clog2(DIV_MAX + 1);
  localparam int          BW        = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d, div_sel;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic [1:0]    speed_q, speed_d;
  logic          step_s1_q, step_s2_q, step_s3_q;
  logic          tick_q, tick_d;
  logic          pc_force_q, pc_force_d;
  logic          halted_q, halted_d;
  logic          led_q, led_d;
  logic [31:0]   cycle_count_q, cycle_count_d;
  logic          step_rise;

  always_comb begin
    case (speed_q)
      2'b00:   div_sel = CW'(DIV_1HZ);
      2'b01:   div_sel = CW'(DIV_10HZ);
      2'b10:   div_sel = CW'(DIV_100HZ);
      default: div_sel = CW'(DIV_FAST);
    endcase
  end

  assign step_rise = step_s2_q & ~step_s3_q;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q       <= S_BOOT;
      div_cnt_q     <= '0;
      boot_cnt_q    <= '0;
      speed_q       <= 2'b00;
      step_s1_q     <= 1'b0;
      step_s2_q     <= 1'b0;
      step_s3_q     <= 1'b0;
      tick_q        <= 1'b0;
      pc_force_q    <= 1'b1;
      halted_q      <= 1'b0;
      led_q         <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      boot_cnt_q    <= boot_cnt_d;
      speed_q       <= speed_d;
      step_s1_q     <= step_btn;
      step_s2_q     <= step_s1_q;
      step_s3_q     <= step_s2_q;
      tick_q        <= tick_d;
      pc_force_q    <= pc_force_d;
      halted_q      <= halted_d;
      led_q         <= led_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    boot_cnt_d    = boot_cnt_q;
    speed_d       = speed_q;
    tick_d        = 1'b0;
    pc_force_d    = pc_force_q;
    halted_d      = halted_q;
    led_d         = led_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      S_BOOT: begin
        speed_d    = speed;
        div_cnt_d  = '0;
        boot_cnt_d = boot_cnt_q + BW'(1);
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
          state_d    = S_RUN;
          pc_force_d = 1'b0;
        end
      end
      S_RUN: begin
        // Bookkeeping for the tick that was just presented to the pipeline
        if (tick_q) begin
          led_d = ~led_q;
          if (inst == FINISH_INST) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (cycle_count_q != 32'hFFFF_FFFF) begin
            cycle_count_d = cycle_count_q + 32'd1;
          end
        end
        // A rate change restarts the period; gating with ~tick_q keeps ticks one clk wide
        if (speed != speed_q) begin
          speed_d   = speed;
          div_cnt_d = '0;
        end else if (run_mode) begin
          if (div_cnt_q >= div_sel - CW'(1)) begin
            div_cnt_d = '0;
            tick_d    = ~tick_q;
          end else begin
            div_cnt_d = div_cnt_q + CW'(1);
          end
        end else begin
          div_cnt_d = '0;
          tick_d    = step_rise & ~tick_q;
        end
      end
      S_HALT: begin
        div_cnt_d = '0;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign cpu_tick    = tick_q;
  assign pc_force    = pc_force_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;
  assign led         = led_q;
  assign state       = state_q;

endmodule

// File: tb/tb_xm23_run_controller.sv
// Scoreboard bench for xm23_run_controller: a segment-level schedule model predicts
// each tick's cycle and bookkeeping; a monitor pops and compares on every cpu_tick.
module tb_xm23_run_controller;

  logic        clk = 1'b0;
  logic        init_n = 1'b1;
  logic [1:0]  speed = 2'b00;
  logic        run_mode = 1'b0;
  logic        step_btn = 1'b0;
  logic [15:0] inst = 16'h0000;
  logic        cpu_tick, pc_force, halted, led;
  logic [31:0] cycle_count;
  logic [1:0]  state;

  xm23_run_controller #(
    .DIV_FAST(6), .DIV_100HZ(20), .DIV_10HZ(9), .DIV_1HZ(13),
    .BOOT_CYCLES(4), .FINISH_INST(16'h3FFF)
  ) dut (
    .clk(clk), .init_n(init_n), .speed(speed), .run_mode(run_mode),
    .step_btn(step_btn), .inst(inst), .cpu_tick(cpu_tick), .pc_force(pc_force),
    .halted(halted), .cycle_count(cycle_count), .led(led), .state(state)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release
  int cyc;
  always @(posedge clk or negedge init_n)
    if (!init_n) cyc <= 0;
    else         cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] cnt;
    logic        led;
    logic        halt;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_cnt;
  logic        m_led;
  logic [1:0]  m_speed;
  logic        m_mode;
  int          m_p;
  int          m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic int divof(input logic [1:0] s);
    case (s)
      2'b11:   return 6;
      2'b10:   return 20;
      2'b01:   return 9;
      default: return 13;
    endcase
  endfunction

  task automatic push_tick(input int t, input logic fin);
    longint nxt;
    if (!fin) begin
      nxt = longint'(m_cnt) + 1;
      if (nxt > 64'h0000_0000_FFFF_FFFF) nxt = 64'h0000_0000_FFFF_FFFF;
      m_cnt = nxt[31:0];
    end
    m_led = ~m_led;
    q.push_back('{t, m_cnt, m_led, fin});
    m_last = t;
  endtask

  // Free run at speed s for len cycles; ticks fall every DIV cycles from the period start
  task automatic run_seg(input logic [1:0] s, input int len);
    int c_end;
    if (!m_mode) begin
      if (s != m_speed) begin
        speed = s;
        m_speed = s;
        @(negedge clk);
      end
      run_mode = 1'b1;
      m_mode = 1'b1;
      m_p = cyc;
    end else if (s != m_speed) begin
      speed = s;
      m_speed = s;
      m_p = cyc + 1;
    end
    c_end = cyc + len;
    while (m_p + divof(m_speed) <= c_end) begin
      m_p = m_p + divof(m_speed);
      push_tick(m_p, 1'b0);
    end
    if (len >= 12) begin
      repeat (2) @(negedge clk);
      step_btn = 1'b1;
      repeat (3) @(negedge clk);
      step_btn = 1'b0;
      repeat (len - 5) @(negedge clk);
    end else begin
      repeat (len) @(negedge clk);
    end
  endtask

  // One button press in step mode: the tick lands three edges after the press is sampled
  task automatic step_seg(input int hold, input int gap);
    if (m_mode) begin
      run_mode = 1'b0;
      m_mode = 1'b0;
      @(negedge clk);
    end
    step_btn = 1'b1;
    push_tick(cyc + 3, 1'b0);
    repeat (hold) @(negedge clk);
    step_btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] s, input logic mode);
    #2;
    check("ticks_outstanding", 32'(q.size()), 32'd0);
    init_n = 1'b0;
    speed = s;
    run_mode = mode;
    step_btn = 1'b0;
    inst = 16'h0000;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_force", 32'(pc_force), 32'd1);
    check("rst_cpu_tick", 32'(cpu_tick), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    q.delete();
    m_cnt = 32'd0;
    m_led = 1'b0;
    m_speed = s;
    m_mode = mode;
    m_p = 4;
    m_last = -100;
    @(negedge clk);
    @(negedge clk);
    init_n = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_tick === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_tick: got tick at cycle %0d, expected none", cyc);
        end else begin
          e = q.pop_front();
          check("tick_cycle", 32'(cyc), 32'(e.t));
          @(negedge clk);
          check("tick_width", 32'(cpu_tick), 32'd0);
          check("tick_cycle_count", cycle_count, e.cnt);
          check("tick_led", 32'(led), 32'(e.led));
          check("tick_halted", 32'(halted), 32'(e.halt));
          check("tick_state", 32'(state), e.halt ? 32'd2 : 32'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    // Boot sequence, then fast free run
    do_reset(2'b11, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("boot_pc_force", 32'(pc_force), (k < 4) ? 32'd1 : 32'd0);
      check("boot_state", 32'(state), (k < 4) ? 32'd0 : 32'd1);
    end
    run_seg(2'b11, 60);
    run_seg(2'b11, 1);
    check("fast_count", cycle_count, 32'd10);
    check("fast_led", 32'(led), 32'd0);
    run_seg(2'b11, 2);
    run_seg(2'b10, 45);
    check("div20_count", cycle_count, 32'd12);

    // Randomized mix of rate changes, free-run segments and step presses
    for (int i = 0; i < 16; i++) begin
      do r = 16'($urandom); while (r == 16'h3FFF);
      inst = r;
      if ($urandom_range(0, 2) != 0)
        run_seg(2'($urandom_range(0, 3)), $urandom_range(5, 60));
      else
        step_seg($urandom_range(1, 40), $urandom_range(4, 15));
    end
    if (m_mode && m_last == cyc) run_seg(m_speed, 1);

    // Finish instruction on the fifth tick
    do_reset(2'b11, 1'b1);
    repeat (4) @(negedge clk);
    run_seg(2'b11, 28);
    inst = 16'h3FFF;
    push_tick(34, 1'b1);
    repeat (8) @(negedge clk);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_state", 32'(state), 32'd2);
    check("halt_count", cycle_count, 32'd4);
    for (int i = 0; i < 10; i++) begin
      speed = 2'($urandom);
      run_mode = 1'($urandom);
      step_btn = ~step_btn;
      repeat (20) @(negedge clk);
    end
    check("halt_frozen_count", cycle_count, 32'd4);
    check("halt_frozen_led", 32'(led), 32'd1);
    check("halt_frozen_state", 32'(state), 32'd2);
    step_btn = 1'b0;

    // Saturation of the executed-cycle counter
    do_reset(2'b00, 1'b0);
    repeat (6) @(negedge clk);
    force dut.cycle_count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_count_q;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    check("preload", cycle_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) step_seg($urandom_range(1, 30), $urandom_range(4, 10));
    check("saturated", cycle_count, 32'hFFFF_FFFF);
    check("saturated_led", 32'(led), 32'd1);

    do_reset(2'b11, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xm23_run_controller.md
Name: xm23_run_controller

Overview:
- Sequences execution of the XM23 pipeline from the 50 MHz board clock.
- Generates a single-cycle CPU advance enable (cpu_tick) at a switch-selected rate, or one tick per button press in single-step mode.
- Holds the program-RAM address force during boot.
- Detects the program-finish instruction (BRA to self, 16'h3FFF) to halt execution and freeze a saturating executed-cycle counter.
- Replaces free-running derived-clock toggling with a clock-enable scheme.

Parameters:
DIV_FAST, 6, clk cycles per tick for speed=2'b11 (8.333 MHz)
DIV_100HZ, 500_000, clk cycles per tick for speed=2'b10
DIV_10HZ, 5_000_000, clk cycles per tick for speed=2'b01
DIV_1HZ, 50_000_000, clk cycles per tick for speed=2'b00
BOOT_CYCLES, 4, clk cycles pc_force is held after reset release (min 2)
FINISH_INST, 16'h3FFF, halt-detect instruction encoding

Ports:
clk  in  1  50 MHz board clock
init_n  in  1  asynchronous active-low reset
speed  in  2  tick-rate select (switches; static or slowly changing)
run_mode  in  1  1 = free run at selected rate, 0 = single step
step_btn  in  1  asynchronous step button level (debounced externally)
inst  in  16  instruction currently presented by program RAM
cpu_tick  out  1  one-clk-wide pipeline advance enable
pc_force  out  1  1 = force program-RAM address to reset vector
halted  out  1  1 = finish instruction executed, ticks stopped
cycle_count  out  32  ticks issued on non-finish instructions, saturating
led  out  1  toggles on every cpu_tick
state  out  2  00 BOOT, 01 RUN, 10 HALT (debug)

Behaviour:
- Reset (init_n low, async) forces:
  - state=BOOT, pc_force=1, cpu_tick=0, halted=0, cycle_count=0, led=0
  - divider count=0, boot count=0
  - step synchronizer flops=0, speed_q=speed-at-release sampled on first edge
- All outputs are registered. No combinational input-to-output paths.
- BOOT:
  - Boot counter increments each clk.
  - When it reaches BOOT_CYCLES-1: state->RUN and pc_force->0 on the same edge.
  - No ticks are issued in BOOT; step edges are discarded.
- Divider select: DIV = {DIV_1HZ, DIV_10HZ, DIV_100HZ, DIV_FAST}[speed]; compare uses speed_q.
- speed_q is a register of speed. On any cycle where speed != speed_q:
  - speed_q updates and the divider count resets to 0.
  - No tick is issued that cycle.
  - The new period starts cleanly.
- RUN with run_mode=1:
  - Divider counts 0..DIV-1.
  - On the edge where count >= DIV-1: cpu_tick<=1 and count<=0. The >= guards against a shrinking divider.
  - Tick period is exactly DIV clk cycles.
  - Step edges are ignored.
- RUN with run_mode=0:
  - Divider is held at 0.
  - step_btn passes through a 2-flop synchronizer, then a third flop for edge detection.
  - A rising edge produces exactly one cpu_tick. It is high during the cycle after the 3rd rising clk edge that samples step_btn high.
  - Holding the button produces no further ticks.
- Mode change step->run: the divider starts from 0, so the first tick comes DIV cycles later.
- cpu_tick is never high for two consecutive clks.
- Tick bookkeeping, evaluated on the edge following a cycle with cpu_tick=1:
  - inst != FINISH_INST: cycle_count += 1, saturating at 32'hFFFF_FFFF with no wrap. led toggles.
  - inst == FINISH_INST: cycle_count unchanged, led toggles, state->HALT, halted<=1.
- HALT:
  - No ticks; divider held at 0; steps and speed changes ignored.
  - Outputs frozen; exit only via init_n.
- Reset mid-operation: asynchronous return to reset values. Any in-flight tick is dropped.

Test Plan:
1. Reset release with BOOT_CYCLES=4 -> pc_force=1 for 4 clks then 0; state 00->01; no cpu_tick during BOOT.
2. DIV_FAST=6, speed=11, run_mode=1, inst=16'h0000, 60 clks after boot -> exactly 10 cpu_tick pulses 6 clks apart, each 1 clk wide; cycle_count=10; led=0 (even toggles).
3. Override DIV_100HZ=20. Switch speed 11->10 mid-period -> no tick on the change cycle; next tick exactly 20 clks after the change; subsequent period 20.
4. run_mode=0; step_btn high for 50 clks, twice -> exactly 2 ticks, each 3 edges after first high sample; cycle_count=2; no ticks between presses.
5. Free run; inst=16'h3FFF at the 5th tick -> cycle_count=4, halted=1, state=10 on the next edge; no further ticks over 200 clks or steps; init_n low clears all.
6. Preload cycle_count near max via long run (or force 32'hFFFF_FFFE) -> two ticks give 32'hFFFF_FFFF and stay there; async init_n pulse mid-period -> immediate reset values.
